// File: rtl/alu_seq_pkg.sv
// Shared types and encodings for the ALU control sequencer: FSM states,
// ALU control codes and the aluop override encodings.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] ALU_ADD     = 4'd0;
  localparam logic [3:0] ALU_SUB     = 4'd1;
  localparam logic [3:0] ALU_MUL     = 4'd2;
  localparam logic [3:0] ALU_DIV     = 4'd3;
  localparam logic [3:0] ALU_AND     = 4'd4;
  localparam logic [3:0] ALU_OR      = 4'd5;
  localparam logic [3:0] ALU_XOR     = 4'd6;
  localparam logic [3:0] ALU_NOR     = 4'd7;
  localparam logic [3:0] ALU_SLL     = 4'd8;
  localparam logic [3:0] ALU_SRL     = 4'd9;
  localparam logic [3:0] ALU_SRA     = 4'd10;
  localparam logic [3:0] ALU_SLT     = 4'd11;
  localparam logic [3:0] ALU_SLTU    = 4'd12;
  localparam logic [3:0] ALU_SEQ     = 4'd13;
  localparam logic [3:0] ALU_SGT     = 4'd14;
  localparam logic [3:0] ALU_ILLEGAL = 4'hF;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_DEC0 = 2'b01;
  localparam logic [1:0] ALUOP_DEC1 = 2'b10;
  localparam logic [1:0] ALUOP_SUB  = 2'b11;

endpackage

// File: rtl/alu_seq_lat_cnt.sv
// Loadable down-counter for multi-cycle op latency; o_term flags count==1.
// Load wins over decrement; clear wins over both. Saturates at zero.
module alu_seq_lat_cnt #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_term
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_term = (r_cnt == CW'(1));

endmodule

// File: rtl/alu_seq_dec.sv
// Registered ALU control sequencer (optional illegal-op flag: ALU_SEQ_TRAP_EN).
// valid_out rises LAT cycles after accept; result held until ready_in, flush aborts.
module alu_seq_dec
  import alu_seq_pkg::*;
#(
  parameter int OPW     = 5,
  parameter int CTRLW   = 4,
  parameter int BASE_OP = 8,
  parameter int NUM_OPS = 15,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [OPW-1:0]   op,
  input  logic [1:0]       aluop,
  input  logic             flush,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [CTRLW-1:0] alucontrol,
  output logic             busy
`ifdef ALU_SEQ_TRAP_EN
  ,
  output logic             illegal
`endif
);

  localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL + 1);
  localparam logic [CW-1:0]    MUL_LD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0]    DIV_LD = CW'(DIV_LAT - 1);
  localparam logic [CTRLW-1:0] ILL    = {CTRLW{1'b1}};

  state_t           r_state;
  logic             r_valid;
  logic             r_busy;
  logic [CTRLW-1:0] r_ctrl;

  logic [31:0]      w_op32;
  logic             w_in_range;
  logic [CTRLW-1:0] w_dec;
  logic [CW-1:0]    w_lat_ld;
  logic             w_multi;
  logic             w_accept;
  logic             w_term;
`ifdef ALU_SEQ_TRAP_EN
  logic             w_dec_ill;
  logic             r_illegal;
`endif

  assign w_op32     = 32'(op);
  assign w_in_range = (w_op32 >= 32'(BASE_OP)) && (w_op32 < 32'(BASE_OP + NUM_OPS));

  // Only op-decoded mult/div get the long latency; forced add/sub never do.
  always_comb begin
    w_dec    = ILL;
    w_lat_ld = '0;
    w_multi  = 1'b0;
`ifdef ALU_SEQ_TRAP_EN
    w_dec_ill = 1'b0;
`endif
    case (aluop)
      ALUOP_ADD: w_dec = CTRLW'(ALU_ADD);
      ALUOP_SUB: w_dec = CTRLW'(ALU_SUB);
      default: begin
        if (w_in_range) begin
          w_dec = CTRLW'(w_op32 - 32'(BASE_OP));
          if (w_dec == CTRLW'(ALU_MUL)) begin
            w_lat_ld = MUL_LD;
            w_multi  = (MUL_LAT > 1);
          end else if (w_dec == CTRLW'(ALU_DIV)) begin
            w_lat_ld = DIV_LD;
            w_multi  = (DIV_LAT > 1);
          end
        end else begin
`ifdef ALU_SEQ_TRAP_EN
          w_dec_ill = 1'b1;
`endif
        end
      end
    endcase
  end

  assign ready_out = !flush && ((r_state == IDLE) || ((r_state == HOLD) && ready_in));
  assign w_accept  = valid_in && ready_out;

  alu_seq_lat_cnt #(
    .CW (CW)
  ) u_lat_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clr      (flush),
    .i_load     (w_accept),
    .i_load_val (w_lat_ld),
    .i_dec      (r_state == EXEC),
    .o_term     (w_term)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_ctrl  <= '0;
`ifdef ALU_SEQ_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else if (flush) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
`ifdef ALU_SEQ_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else if (w_accept) begin
      r_ctrl <= w_dec;
`ifdef ALU_SEQ_TRAP_EN
      r_illegal <= w_dec_ill;
`endif
      if (w_multi) begin
        r_state <= EXEC;
        r_valid <= 1'b0;
        r_busy  <= 1'b1;
      end else begin
        r_state <= HOLD;
        r_valid <= 1'b1;
        r_busy  <= 1'b0;
      end
    end else begin
      case (r_state)
        EXEC: begin
          if (w_term) begin
            r_state <= HOLD;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        HOLD: begin
          if (ready_in) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid_out  = r_valid;
  assign busy       = r_busy;
  assign alucontrol = r_ctrl;
`ifdef ALU_SEQ_TRAP_EN
  assign illegal    = r_illegal;
`endif

endmodule

// File: tb/tb_alu_seq_dec.sv
// Bench for alu_seq_dec: directed scenarios plus randomized requests against a
// rule-level reference model of decode, latency and handshake timing.
module tb_alu_seq_dec;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       valid_in = 1'b0;
  logic       flush = 1'b0;
  logic       ready_in = 1'b0;
  logic [4:0] op = '0;
  logic [1:0] aluop = '0;
  logic       ready_out;
  logic       valid_out;
  logic       busy;
  logic [3:0] alucontrol;
`ifdef ALU_SEQ_TRAP_EN
  logic       illegal;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  alu_seq_dec dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .op         (op),
    .aluop      (aluop),
    .flush      (flush),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .alucontrol (alucontrol),
    .busy       (busy)
`ifdef ALU_SEQ_TRAP_EN
    ,
    .illegal    (illegal)
`endif
  );

  function automatic logic [3:0] model_ctrl(input logic [1:0] a, input logic [4:0] o);
    int v;
    v = int'(o);
    if (a == 2'b00) return 4'd0;
    if (a == 2'b11) return 4'd1;
    if (v >= 8 && v <= 22) return 4'(v - 8);
    return 4'hF;
  endfunction

  function automatic int model_lat(input logic [1:0] a, input logic [4:0] o);
    if (a == 2'b01 || a == 2'b10) begin
      if (int'(o) == 10) return 4;
      if (int'(o) == 11) return 8;
    end
    return 1;
  endfunction

  function automatic logic model_ill(input logic [1:0] a, input logic [4:0] o);
    return (a == 2'b01 || a == 2'b10) && !(int'(o) >= 8 && int'(o) <= 22);
  endfunction

  // One request from IDLE, hold cycles of ready_in=0 once valid, then consume.
  task automatic run_req(input logic [1:0] a, input logic [4:0] o, input int hold, input string tag);
    logic [3:0] ec;
    int         lat;
    ec  = model_ctrl(a, o);
    lat = model_lat(a, o);
    @(negedge clk);
    aluop = a; op = o; valid_in = 1'b1; ready_in = 1'b0;
    #1;
    vectors++;
    if (ready_out !== 1'b1) begin errors++; $display("FAIL %s ready_idle got %b want 1", tag, ready_out); end
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) valid_in = 1'b0;
      vectors++;
      if (valid_out !== (k == lat) || busy !== (k < lat)) begin
        errors++;
        $display("FAIL %s timing cyc%0d got v=%b b=%b want v=%b b=%b", tag, k, valid_out, busy, (k == lat), (k < lat));
      end
    end
    vectors++;
    if (alucontrol !== ec) begin errors++; $display("FAIL %s ctrl got %h want %h", tag, alucontrol, ec); end
`ifdef ALU_SEQ_TRAP_EN
    vectors++;
    if (illegal !== model_ill(a, o)) begin errors++; $display("FAIL %s illegal got %b want %b", tag, illegal, model_ill(a, o)); end
`endif
    vectors++;
    if (ready_out !== 1'b0) begin errors++; $display("FAIL %s ready_hold got %b want 0", tag, ready_out); end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      vectors++;
      if (valid_out !== 1'b1 || alucontrol !== ec || ready_out !== 1'b0) begin
        errors++;
        $display("FAIL %s stall%0d got v=%b c=%h r=%b want v=1 c=%h r=0", tag, h, valid_out, alucontrol, ready_out, ec);
      end
    end
    ready_in = 1'b1;
    #1;
    vectors++;
    if (ready_out !== 1'b1) begin errors++; $display("FAIL %s ready_consume got %b want 1", tag, ready_out); end
    @(negedge clk);
    ready_in = 1'b0;
    vectors++;
    if (valid_out !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s idle_after got v=%b b=%b want 0 0", tag, valid_out, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    vectors++;
    if (valid_out !== 1'b0 || busy !== 1'b0 || alucontrol !== 4'd0) begin
      errors++; $display("FAIL reset_state got v=%b b=%b c=%h want 0 0 0", valid_out, busy, alucontrol);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    vectors++;
    if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_out); end
  endtask

  task automatic test_add();
    run_req(2'b00, 5'b01010, 0, "add_force");
    run_req(2'b11, 5'b01010, 1, "sub_force");
  endtask

  task automatic test_mul();
    run_req(2'b10, 5'b01010, 0, "mul");
  endtask

  task automatic test_div_hold();
    run_req(2'b10, 5'b01011, 3, "div_hold");
  endtask

  task automatic test_illegal();
    run_req(2'b01, 5'b00011, 0, "illegal_lo");
    run_req(2'b01, 5'b01000, 0, "legal_base");
    run_req(2'b10, 5'b10111, 0, "illegal_hi");
  endtask

  task automatic test_back_to_back();
    logic [4:0] ops [3];
    ops[0] = 5'b01000; ops[1] = 5'b01100; ops[2] = 5'b10110;
    @(negedge clk);
    aluop = 2'b10; ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op = ops[i]; valid_in = 1'b1;
      #1;
      vectors++;
      if (ready_out !== 1'b1) begin errors++; $display("FAIL b2b ready%0d got %b want 1", i, ready_out); end
      @(negedge clk);
      vectors++;
      if (valid_out !== 1'b1 || alucontrol !== model_ctrl(2'b10, ops[i])) begin
        errors++; $display("FAIL b2b op%0d got v=%b c=%h want v=1 c=%h", i, valid_out, alucontrol, model_ctrl(2'b10, ops[i]));
      end
    end
    valid_in = 1'b0;
    @(negedge clk);
    ready_in = 1'b0;
    vectors++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL b2b drain got %b want 0", valid_out); end
  endtask

  task automatic test_flush();
    logic seen;
    @(negedge clk);
    aluop = 2'b10; op = 5'b01011; valid_in = 1'b1; ready_in = 1'b0;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1; valid_in = 1'b1; aluop = 2'b00; op = 5'd0;
    #1;
    vectors++;
    if (ready_out !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", ready_out); end
    @(negedge clk);
    flush = 1'b0; valid_in = 1'b0;
    #1;
    vectors++;
    if (valid_out !== 1'b0 || busy !== 1'b0 || alucontrol !== 4'd3 || ready_out !== 1'b1) begin
      errors++; $display("FAIL flush_state got v=%b b=%b c=%h r=%b want 0 0 3 1", valid_out, busy, alucontrol, ready_out);
    end
    seen = 1'b0;
    repeat (10) begin @(negedge clk); seen = seen | valid_out | busy; end
    vectors++;
    if (seen !== 1'b0) begin errors++; $display("FAIL flush_quiet got %b want 0", seen); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(negedge clk);
    aluop = 2'b01; op = 5'b01011; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    vectors++;
    if (valid_out !== 1'b0 || busy !== 1'b0 || alucontrol !== 4'd0) begin
      errors++; $display("FAIL rstmid got v=%b b=%b c=%h want 0 0 0", valid_out, busy, alucontrol);
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); seen = seen | valid_out | busy; end
    vectors++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_quiet got %b want 0", seen); end
  endtask

  task automatic test_random();
    logic [1:0] a;
    logic [4:0] o;
    for (int i = 0; i < 30; i++) begin
      a = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       o = 5'd10;
        1:       o = 5'd11;
        default: o = 5'($urandom_range(0, 31));
      endcase
      run_req(a, o, int'($urandom_range(0, 2)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div_hold();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
